div_two_counter: RTL and testbench

- Divide-by-two clock generator: a single toggle flip-flop producing a clock at half the input clock frequency.
- Gated by an enable and cleared by a synchronous reset.
- Used wherever a derived half-rate clock or toggle strobe is needed in the design.
- clk_out is a registered signal; it is glitch-free and changes only on the rising edge of clk_in.

---
 rtl/div_two_counter_if.sv | 29 ++
 rtl/div_two_counter.sv | 57 +++++
 tb/tb_div_two_counter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_two_counter_if.sv
// ---------------------------------------------------------------------------
// div_two_counter_if
//
// Purpose:
//   Groups the functional signals of the divide-by-two counter into one
//   bundle. The clock and reset of the counter stay as plain module ports.
//
// Signals:
//   enable   - active-high toggle enable, driven by the controlling logic
//   clk_out  - divided clock, driven by the counter
//
// Modports:
//   master   - the controlling side: drives enable, observes clk_out
//   slave    - the counter itself: receives enable, drives clk_out
// ---------------------------------------------------------------------------
interface div_two_counter_if;
    logic enable;
    logic clk_out;

    modport master (
        output enable,
        input  clk_out
    );

    modport slave (
        input  enable,
        output clk_out
    );
endinterface

// File: rtl/div_two_counter.sv
// ---------------------------------------------------------------------------
// div_two_counter
//
// Purpose:
//   Divide-by-two clock generator built from a single toggle flip-flop.
//   With enable held high the output runs at half the input clock rate with
//   a 50% duty cycle. The output comes straight from the flop, so it is
//   glitch-free and only ever changes on the rising edge of clk_in.
//
// Parameters:
//   RESET_VALUE - level loaded into clk_out on an edge that samples reset high
//
// Ports:
//   clk_in   - input clock; all state changes on its rising edge
//   reset    - synchronous, active-high reset; overrides enable
//   bus      - slave side of div_two_counter_if
//                bus.enable  : toggle enable (input)
//                bus.clk_out : divided clock (output)
//
// Notes:
//   enable and reset must already be synchronous to clk_in; nothing in here
//   resynchronises them. Until the first edge that samples reset high the
//   state of the flop is unknown.
// ---------------------------------------------------------------------------
module div_two_counter #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic               clk_in,
    input  logic               reset,
    div_two_counter_if.slave   bus
);

    logic q_q;
    logic q_d;

    // Toggle when enabled, otherwise hold. An enable drop freezes the output
    // at whatever level it happens to be, and toggling resumes from there.
    always_comb begin
        q_d = q_q;
        if (bus.enable) begin
            q_d = ~q_q;
        end
    end

    // Reset is checked first so it wins over a simultaneous enable.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    // Output is the flop itself; no logic after the register.
    assign bus.clk_out = q_q;

endmodule

// File: tb/tb_div_two_counter.sv
module tb_div_two_counter;

    logic clk_in = 1'b0;
    logic reset;

    div_two_counter_if if0 ();
    div_two_counter_if if1 ();

    div_two_counter #(.RESET_VALUE(1'b0)) dut0 (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (if0)
    );

    div_two_counter #(.RESET_VALUE(1'b1)) dut1 (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (if1)
    );

    // Period 10: rising edges at 5, 15, 25, ...; falling edges at 10, 20, ...
    always #5 clk_in = ~clk_in;

    int   checks = 0;
    int   errors = 0;
    logic exp0;
    logic exp1;

    // One line per clock transaction, printed on the sampling edge.
    always @(negedge clk_in) begin
        $display("t=%0t reset=%b enable=%b clk_out0=%b clk_out1=%b",
                 $time, reset, if0.enable, if0.clk_out, if1.clk_out);
    end

    task automatic set_en(input logic v);
        if0.enable = v;
        if1.enable = v;
    endtask

    // Reset held across the first edge with enable high, then released.
    task automatic test_reset;
        reset = 1'b1;
        set_en(1'b1);
        @(negedge clk_in);
        exp0 = 1'b0;
        exp1 = 1'b1;
        checks++;
        if (if0.clk_out !== exp0) begin
            errors++;
            $display("FAIL reset_rv0: got %b expected %b", if0.clk_out, exp0);
        end
        checks++;
        if (if1.clk_out !== exp1) begin
            errors++;
            $display("FAIL reset_rv1: got %b expected %b", if1.clk_out, exp1);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            exp0 = ~exp0;
            exp1 = ~exp1;
            checks++;
            if (if0.clk_out !== exp0) begin
                errors++;
                $display("FAIL reset_release_rv0 step %0d: got %b expected %b", i, if0.clk_out, exp0);
            end
            checks++;
            if (if1.clk_out !== exp1) begin
                errors++;
                $display("FAIL reset_release_rv1 step %0d: got %b expected %b", i, if1.clk_out, exp1);
            end
        end
    endtask

    // 90 enabled edges starting from 0: output toggles every edge and
    // produces exactly 45 rising edges.
    task automatic test_steady_divide;
        int   rises;
        logic prev;
        rises = 0;
        for (int i = 0; i < 90; i++) begin
            prev = if0.clk_out;
            @(negedge clk_in);
            exp0 = ~exp0;
            exp1 = ~exp1;
            if (prev === 1'b0 && if0.clk_out === 1'b1) rises++;
            checks++;
            if (if0.clk_out !== exp0) begin
                errors++;
                $display("FAIL steady_rv0 step %0d: got %b expected %b", i, if0.clk_out, exp0);
            end
            checks++;
            if (if1.clk_out !== exp1) begin
                errors++;
                $display("FAIL steady_rv1 step %0d: got %b expected %b", i, if1.clk_out, exp1);
            end
        end
        checks++;
        if (rises !== 45) begin
            errors++;
            $display("FAIL steady_rise_count: got %0d expected 45", rises);
        end
    endtask

    // One toggle to reach clk_out0=1, then a single-cycle reset pulse.
    task automatic test_reset_mid;
        @(negedge clk_in);
        exp0 = ~exp0;
        exp1 = ~exp1;
        checks++;
        if (if0.clk_out !== 1'b1 || if0.clk_out !== exp0) begin
            errors++;
            $display("FAIL mid_pre_rv0: got %b expected 1", if0.clk_out);
        end
        reset = 1'b1;
        @(negedge clk_in);
        exp0 = 1'b0;
        exp1 = 1'b1;
        checks++;
        if (if0.clk_out !== exp0) begin
            errors++;
            $display("FAIL mid_reset_rv0: got %b expected %b", if0.clk_out, exp0);
        end
        checks++;
        if (if1.clk_out !== exp1) begin
            errors++;
            $display("FAIL mid_reset_rv1: got %b expected %b", if1.clk_out, exp1);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            exp0 = ~exp0;
            exp1 = ~exp1;
            checks++;
            if (if0.clk_out !== exp0) begin
                errors++;
                $display("FAIL mid_restart_rv0 step %0d: got %b expected %b", i, if0.clk_out, exp0);
            end
            checks++;
            if (if1.clk_out !== exp1) begin
                errors++;
                $display("FAIL mid_restart_rv1 step %0d: got %b expected %b", i, if1.clk_out, exp1);
            end
        end
    endtask

    // Drop enable while clk_out0 is high: it must freeze high, then resume.
    task automatic test_enable_gating;
        if (exp0 == 1'b0) begin
            @(negedge clk_in);
            exp0 = ~exp0;
            exp1 = ~exp1;
            checks++;
            if (if0.clk_out !== exp0) begin
                errors++;
                $display("FAIL gate_setup_rv0: got %b expected %b", if0.clk_out, exp0);
            end
        end
        set_en(1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            checks++;
            if (if0.clk_out !== 1'b1) begin
                errors++;
                $display("FAIL gate_hold_rv0 step %0d: got %b expected 1", i, if0.clk_out);
            end
            checks++;
            if (if1.clk_out !== 1'b0) begin
                errors++;
                $display("FAIL gate_hold_rv1 step %0d: got %b expected 0", i, if1.clk_out);
            end
        end
        set_en(1'b1);
        @(negedge clk_in);
        exp0 = 1'b0;
        exp1 = 1'b1;
        checks++;
        if (if0.clk_out !== exp0) begin
            errors++;
            $display("FAIL gate_resume_rv0: got %b expected %b", if0.clk_out, exp0);
        end
        checks++;
        if (if1.clk_out !== exp1) begin
            errors++;
            $display("FAIL gate_resume_rv1: got %b expected %b", if1.clk_out, exp1);
        end
    endtask

    // Reset and enable both high for 4 edges: each output sits at its reset value.
    task automatic test_reset_override;
        reset = 1'b1;
        set_en(1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            checks++;
            if (if0.clk_out !== 1'b0) begin
                errors++;
                $display("FAIL override_rv0 step %0d: got %b expected 0", i, if0.clk_out);
            end
            checks++;
            if (if1.clk_out !== 1'b1) begin
                errors++;
                $display("FAIL override_rv1 step %0d: got %b expected 1", i, if1.clk_out);
            end
        end
        reset = 1'b0;
        exp0 = 1'b0;
        exp1 = 1'b1;
        @(negedge clk_in);
        exp0 = ~exp0;
        exp1 = ~exp1;
        checks++;
        if (if0.clk_out !== exp0) begin
            errors++;
            $display("FAIL override_release_rv0: got %b expected %b", if0.clk_out, exp0);
        end
        checks++;
        if (if1.clk_out !== exp1) begin
            errors++;
            $display("FAIL override_release_rv1: got %b expected %b", if1.clk_out, exp1);
        end
    endtask

    // Short reset pulses that never cover a rising edge must be ignored.
    task automatic test_reset_not_async;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                // Pulse in the low half of clk_in, before the rising edge.
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end else begin
                // Pulse just after the rising edge.
                @(posedge clk_in);
                #1 reset = 1'b1;
                #2 reset = 1'b0;
            end
            @(negedge clk_in);
            exp0 = ~exp0;
            exp1 = ~exp1;
            checks++;
            if (if0.clk_out !== exp0) begin
                errors++;
                $display("FAIL glitch_reset_rv0 step %0d: got %b expected %b", i, if0.clk_out, exp0);
            end
            checks++;
            if (if1.clk_out !== exp1) begin
                errors++;
                $display("FAIL glitch_reset_rv1 step %0d: got %b expected %b", i, if1.clk_out, exp1);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        set_en(1'b1);
        test_reset();
        test_steady_divide();
        test_reset_mid();
        test_enable_gating();
        test_reset_override();
        test_reset_not_async();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
